// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, defaults and FSM encoding for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [INST_WIDTH-1:0] word_align(input logic [INST_WIDTH-1:0] pc);
        return {pc[INST_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    logic                  imem_req;
    logic [INST_WIDTH-1:0] imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold on stall, otherwise drain to a bubble.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] RESET_PC = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  hold,
    input  logic [INST_WIDTH-1:0] pc_in,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic [INST_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_valid
);

    // Clear outranks hold so a flush kills a stalled instruction; id_pc is left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= RESET_PC;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (clear) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (load) begin
            id_pc    <= pc_in;
            id_inst  <= inst_in;
            id_valid <= 1'b1;
        end else if (!hold) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, sequences single-outstanding imem requests and feeds IF/ID.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INST_WIDTH-1:0] next_pc,
    input  logic                  pipelineFlush,
    input  logic                  stall,
    output logic [INST_WIDTH-1:0] curr_pc,
    if_fetch_stage_if.master      imem,
    output logic [INST_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_valid
);

    fetch_state_t          state, state_n;
    logic                  drop, drop_n;
    logic [INST_WIDTH-1:0] pc_n;
    logic [INST_WIDTH-1:0] skid, skid_n;
    logic                  deliver;
    logic [INST_WIDTH-1:0] deliver_inst;

    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = word_align(curr_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            drop    <= 1'b0;
            curr_pc <= RESET_PC;
            skid    <= '0;
        end else begin
            state   <= state_n;
            drop    <= drop_n;
            curr_pc <= pc_n;
            skid    <= skid_n;
        end
    end

    always_comb begin
        state_n      = state;
        drop_n       = drop;
        pc_n         = curr_pc;
        skid_n       = skid;
        deliver      = 1'b0;
        deliver_inst = imem.imem_rdata;

        if (pipelineFlush) begin
            pc_n = next_pc;
            unique case (state)
                ST_FETCH: begin
                    // An accepted request still returns data for the old address.
                    if (imem.imem_gnt) begin
                        state_n = ST_WAIT;
                        drop_n  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        state_n = ST_FETCH;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_n = ST_FETCH;
                    drop_n  = 1'b0;
                end
                default: state_n = ST_FETCH;
            endcase
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (imem.imem_gnt) state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = ST_FETCH;
                        end else if (!stall) begin
                            deliver = 1'b1;
                            pc_n    = next_pc;
                            state_n = ST_FETCH;
                        end else begin
                            skid_n  = imem.imem_rdata;
                            state_n = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    deliver_inst = skid;
                    if (!stall) begin
                        deliver = 1'b1;
                        pc_n    = next_pc;
                        state_n = ST_FETCH;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .clear    (pipelineFlush),
        .load     (deliver),
        .hold     (stall),
        .pc_in    (curr_pc),
        .inst_in  (deliver_inst),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a hand-driven imem bus.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        pipelineFlush;
    logic [31:0] curr_pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    int          checks   = 0;
    int          failures = 0;

    if_fetch_stage_if imem ();

    always #5 clk = ~clk;

    assign pipelineFlush = redirect;
    always_comb next_pc = redirect ? target : curr_pc + 32'd4;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .next_pc       (next_pc),
        .pipelineFlush (pipelineFlush),
        .stall         (stall),
        .curr_pc       (curr_pc),
        .imem          (imem),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0;
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (curr_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", curr_pc, 32'h0); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if (id_inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (imem.imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", imem.imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] insts [2];
        insts[0] = 32'h1111_0013;
        insts[1] = 32'h2222_0013;
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem.imem_addr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem.imem_addr, 32'(4 * i)); end
            imem.imem_gnt = 1'b1;
            tick();
            imem.imem_gnt = 1'b0;
            checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL seq_wait_req%0d got=%b exp=0", i, imem.imem_req); end
            checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL seq_bubble%0d got=%b exp=0", i, id_valid); end
            imem.imem_rvalid = 1'b1; imem.imem_rdata = insts[i];
            tick();
            imem.imem_rvalid = 1'b0;
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, id_valid); end
            checks++; if (id_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_id_pc%0d got=%h exp=%h", i, id_pc, 32'(4 * i)); end
            checks++; if (id_inst !== insts[i]) begin failures++; $display("FAIL seq_inst%0d got=%h exp=%h", i, id_inst, insts[i]); end
        end
        checks++; if (imem.imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr2 got=%h exp=8", imem.imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1; imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h00A0_0093;
        tick();
        imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'hDEAD_BEEF;
        checks++; if (dut.state !== ST_HOLD) begin failures++; $display("FAIL stall_state got=%0d exp=%0d", dut.state, ST_HOLD); end
        checks++; if (curr_pc !== 32'h8) begin failures++; $display("FAIL stall_pc got=%h exp=8", curr_pc); end
        checks++; if (id_pc !== 32'h4 || id_valid !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%b exp=4/1", id_pc, id_valid); end
        tick();
        checks++; if (id_inst !== 32'h2222_0013) begin failures++; $display("FAIL stall_hold_inst got=%h exp=22220013", id_inst); end
        stall = 1'b0;
        tick();
        checks++; if (id_inst !== 32'h00A0_0093) begin failures++; $display("FAIL skid_inst got=%h exp=00a00093", id_inst); end
        checks++; if (id_pc !== 32'h8) begin failures++; $display("FAIL skid_pc got=%h exp=8", id_pc); end
        checks++; if (curr_pc !== 32'hC) begin failures++; $display("FAIL skid_next got=%h exp=c", curr_pc); end
    endtask

    task automatic test_flush_wait();
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; redirect = 1'b1; target = 32'h100;
        tick();
        redirect = 1'b0;
        checks++; if (curr_pc !== 32'h100) begin failures++; $display("FAIL fw_pc got=%h exp=100", curr_pc); end
        checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL fw_req got=%b exp=0", imem.imem_req); end
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fw_discard got=%b exp=0", id_valid); end
        checks++; if (imem.imem_addr !== 32'h100 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL fw_addr got=%h/%b exp=100/1", imem.imem_addr, imem.imem_req); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0000_0113;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_pc !== 32'h100 || id_valid !== 1'b1 || id_inst !== 32'h0000_0113) begin failures++; $display("FAIL fw_deliver got=%h/%b/%h exp=100/1/00000113", id_pc, id_valid, id_inst); end
    endtask

    task automatic test_flush_gnt();
        redirect = 1'b1; target = 32'h200; imem.imem_gnt = 1'b1;
        tick();
        redirect = 1'b0; imem.imem_gnt = 1'b0;
        checks++; if (dut.drop !== 1'b1) begin failures++; $display("FAIL fg_drop got=%b exp=1", dut.drop); end
        checks++; if (curr_pc !== 32'h200) begin failures++; $display("FAIL fg_pc got=%h exp=200", curr_pc); end
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hBAD0_0BAD;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fg_discard got=%b exp=0", id_valid); end
        checks++; if (imem.imem_addr !== 32'h200 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL fg_addr got=%h/%b exp=200/1", imem.imem_addr, imem.imem_req); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0000_0213;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_pc !== 32'h200 || id_valid !== 1'b1) begin failures++; $display("FAIL fg_deliver got=%h/%b exp=200/1", id_pc, id_valid); end
        checks++; if (curr_pc !== 32'h204) begin failures++; $display("FAIL fg_next got=%h exp=204", curr_pc); end
    endtask

    task automatic test_flush_hold();
        stall = 1'b1; imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h1111_1111;
        tick();
        imem.imem_rvalid = 1'b0;
        redirect = 1'b1; target = 32'h302;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin failures++; $display("FAIL fh_kill got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
        checks++; if (curr_pc !== 32'h302) begin failures++; $display("FAIL fh_pc got=%h exp=302", curr_pc); end
        checks++; if (imem.imem_addr !== 32'h300 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL fh_addr got=%h/%b exp=300/1", imem.imem_addr, imem.imem_req); end
        imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h2222_2222;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_inst !== 32'h2222_2222) begin failures++; $display("FAIL fh_inst got=%h exp=22222222", id_inst); end
        checks++; if (id_pc !== 32'h302) begin failures++; $display("FAIL fh_id_pc got=%h exp=302", id_pc); end
        checks++; if (curr_pc !== 32'h306) begin failures++; $display("FAIL fh_next got=%h exp=306", curr_pc); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0; imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0000_0513;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_id_pc got=%h exp=fffffffc", id_pc); end
        checks++; if (curr_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", curr_pc); end
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; target = 32'h40;
        tick();
        redirect = 1'b0; imem.imem_gnt = 1'b1;
        tick();
        imem.imem_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (curr_pc !== 32'h0 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL rm_reset got=%h/%b exp=0/1", curr_pc, imem.imem_req); end
        imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hBADB_AD00;
        tick();
        imem.imem_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin failures++; $display("FAIL rm_stale got=%b/%h exp=0/%h", id_valid, id_inst, NOP); end
        checks++; if (curr_pc !== 32'h0 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL rm_fetch got=%h/%b exp=0/1", curr_pc, imem.imem_req); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush_wait();
        test_flush_gnt();
        test_flush_hold();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
